// File: rtl/capture_scheduler.sv
// Frame-capture sequencer for two camera pipelines: periodic/one-shot starts,
// FIFO/busy hold-off, per-capture watchdog with camera reset recovery.
module capture_scheduler #(
  parameter int PERIOD_W   = 32,
  parameter int TIMEOUT_W  = 24,
  parameter int COUNT_W    = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [PERIOD_W-1:0]  period,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic                 trigger,
  input  logic                 clear_err,
  input  logic                 cam0_busy,
  input  logic                 cam1_busy,
  input  logic                 cam0_done,
  input  logic                 cam1_done,
  input  logic                 cam0_fifo_afull,
  input  logic                 cam1_fifo_afull,
  output logic                 cam0_start,
  output logic                 cam1_start,
  output logic                 cam0_reset,
  output logic                 cam1_reset,
  output logic                 sched_busy,
  output logic                 next_cam,
  output logic [COUNT_W-1:0]   frame_count,
  output logic                 timeout_err,
  output logic                 overrun
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_START, S_WAIT, S_RECOVER} state_t;

  localparam int RC_W = $clog2(RST_CYCLES + 1);

  state_t               state_q, state_d;
  logic [PERIOD_W-1:0]  cnt_q, cnt_d, per_q, per_d;
  logic                 pend_q, pend_d;
  logic [1:0]           tgt_q, tgt_d, done_q, done_d;
  logic                 alt_q, alt_d, nxt_q, nxt_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [RC_W-1:0]      rc_q, rc_d;
  logic [COUNT_W-1:0]   fc_q, fc_d;
  logic                 terr_q, terr_d, ovr_q, ovr_d;
  logic                 tick, accept, set_terr, set_ovr;
  logic [1:0]           mode_tgt, hold_v, done_v, done_new;

  assign hold_v = {cam1_busy | cam1_fifo_afull, cam0_busy | cam0_fifo_afull};
  assign done_v = {cam1_done, cam0_done};

  // Period is sampled at each wrap (or while disabled) so a live change never
  // shortens or stretches the interval already in progress.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    per_d = per_q;
    if (!enable) begin
      cnt_d = '0;
      per_d = period;
    end else begin
      tick = (per_q == '0) || (cnt_q == per_q - PERIOD_W'(1));
      if (tick) begin
        cnt_d = '0;
        per_d = period;
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
    end
  end

  always_comb begin
    case (mode)
      2'b00:   mode_tgt = 2'b01;
      2'b01:   mode_tgt = 2'b10;
      2'b10:   mode_tgt = nxt_q ? 2'b10 : 2'b01;
      default: mode_tgt = 2'b11;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    alt_d    = alt_q;
    done_d   = done_q;
    wd_d     = wd_q;
    rc_d     = rc_q;
    fc_d     = fc_q;
    nxt_d    = nxt_q;
    accept   = 1'b0;
    set_terr = 1'b0;
    done_new = done_q | (done_v & tgt_q);
    case (state_q)
      S_IDLE: begin
        accept = pend_q | trigger;
        if (accept) begin
          tgt_d   = mode_tgt;
          alt_d   = (mode == 2'b10);
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if ((hold_v & tgt_q) == 2'b00) state_d = S_START;
      end
      S_START: begin
        done_d  = 2'b00;
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        done_d = done_new;
        wd_d   = wd_q + TIMEOUT_W'(1);
        // Completion is tested first so a last done coinciding with expiry wins.
        if ((done_new & tgt_q) == tgt_q) begin
          fc_d    = fc_q + COUNT_W'(1);
          nxt_d   = nxt_q ^ alt_q;
          state_d = S_IDLE;
        end else if ((timeout != '0) && (wd_q + TIMEOUT_W'(1) == timeout)) begin
          set_terr = 1'b1;
          rc_d     = '0;
          state_d  = S_RECOVER;
        end
      end
      S_RECOVER: begin
        rc_d = rc_q + RC_W'(1);
        if (rc_q == RC_W'(RST_CYCLES - 1)) begin
          nxt_d   = nxt_q ^ alt_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A tick that lands while one is still queued behind an active capture is lost.
  assign set_ovr = tick && pend_q && (state_q != S_IDLE) && (per_q != '0);

  always_comb begin
    if (!enable)     pend_d = 1'b0;
    else if (tick)   pend_d = 1'b1;
    else if (accept) pend_d = 1'b0;
    else             pend_d = pend_q;
    terr_d = set_terr ? 1'b1 : (clear_err ? 1'b0 : terr_q);
    ovr_d  = set_ovr  ? 1'b1 : (clear_err ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      pend_q  <= 1'b0;
      tgt_q   <= 2'b00;
      done_q  <= 2'b00;
      alt_q   <= 1'b0;
      nxt_q   <= 1'b0;
      wd_q    <= '0;
      rc_q    <= '0;
      fc_q    <= '0;
      terr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
      alt_q   <= alt_d;
      nxt_q   <= nxt_d;
      wd_q    <= wd_d;
      rc_q    <= rc_d;
      fc_q    <= fc_d;
      terr_q  <= terr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign cam0_start  = (state_q == S_START) && tgt_q[0];
  assign cam1_start  = (state_q == S_START) && tgt_q[1];
  assign cam0_reset  = (state_q == S_RECOVER) && tgt_q[0] && !done_q[0];
  assign cam1_reset  = (state_q == S_RECOVER) && tgt_q[1] && !done_q[1];
  assign sched_busy  = (state_q != S_IDLE);
  assign next_cam    = nxt_q;
  assign frame_count = fc_q;
  assign timeout_err = terr_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_capture_scheduler.sv
// Bench for capture_scheduler: start masks scoreboarded from a queue, one-shot
// vectors from a table, hand-written sequences for periodic, hold-off, watchdog and reset.
module tb_capture_scheduler;
  localparam int PW = 32;
  localparam int TW = 24;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [PW-1:0] period = '0;
  logic [TW-1:0] timeout = '0;
  logic          trigger = 1'b0;
  logic          clear_err = 1'b0;
  logic          cam0_busy = 1'b0, cam1_busy = 1'b0;
  logic          cam0_done = 1'b0, cam1_done = 1'b0;
  logic          cam0_fifo_afull = 1'b0, cam1_fifo_afull = 1'b0;
  logic          cam0_start, cam1_start, cam0_reset, cam1_reset;
  logic          sched_busy, next_cam, timeout_err, overrun;
  logic [CW-1:0] frame_count;

  capture_scheduler #(.PERIOD_W(PW), .TIMEOUT_W(TW), .COUNT_W(CW), .RST_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .period(period),
    .timeout(timeout), .trigger(trigger), .clear_err(clear_err),
    .cam0_busy(cam0_busy), .cam1_busy(cam1_busy),
    .cam0_done(cam0_done), .cam1_done(cam1_done),
    .cam0_fifo_afull(cam0_fifo_afull), .cam1_fifo_afull(cam1_fifo_afull),
    .cam0_start(cam0_start), .cam1_start(cam1_start),
    .cam0_reset(cam0_reset), .cam1_reset(cam1_reset),
    .sched_busy(sched_busy), .next_cam(next_cam), .frame_count(frame_count),
    .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Scoreboard: expected start masks {cam1,cam0}, consumed as starts appear.
  logic [1:0] exp_q[$];
  int         starts[$];
  int         last_start = 0;

  initial forever begin
    @(negedge clk);
    if (cam0_start || cam1_start) begin
      last_start = cyc;
      starts.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_start", 32'({cam1_start, cam0_start}), 32'd0);
      else check("start_mask", 32'({cam1_start, cam0_start}), 32'(exp_q.pop_front()));
    end
  end

  // Camera model: returns done dlyN cycles after a start, if enabled.
  logic [1:0] resp_en = 2'b00;
  int dly0 = 3, dly1 = 3, c0 = 0, c1 = 0;

  initial forever begin
    @(negedge clk);
    cam0_done = 1'b0;
    cam1_done = 1'b0;
    if (c0 > 0) begin c0--; if (c0 == 0) cam0_done = 1'b1; end
    if (c1 > 0) begin c1--; if (c1 == 0) cam1_done = 1'b1; end
    if (cam0_start && resp_en[0]) c0 = dly0;
    if (cam1_start && resp_en[1]) c1 = dly1;
  end

  task automatic wait_idle(input int lim, output int fall);
    int n = 0;
    while (sched_busy && n < lim) begin @(negedge clk); n++; end
    check("idle_reached", 32'(sched_busy), 32'd0);
    fall = cyc;
  endtask

  task automatic trigger_pulse(output int tc);
    @(negedge clk); trigger = 1'b1; tc = cyc;
    @(negedge clk); trigger = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
  endtask

  task automatic run_periodic(input int nstarts, input int lim);
    int n = 0;
    int f;
    @(negedge clk); enable = 1'b1;
    while (starts.size() < nstarts && n < lim) begin @(negedge clk); n++; end
    enable = 1'b0;
    wait_idle(300, f);
    check("periodic_start_count", 32'(starts.size()), 32'(nstarts));
  endtask

  typedef struct { logic [1:0] mode; logic [1:0] mask; logic nxt_after; } vec_t;
  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [CW-1:0] fc_exp;
    int tc, f, n, r0, r1, te, dc;
    fc_exp = '0;

    tbl[0] = '{2'b00, 2'b01, 1'b0};
    tbl[1] = '{2'b01, 2'b10, 1'b0};
    tbl[2] = '{2'b11, 2'b11, 1'b0};
    tbl[3] = '{2'b10, 2'b01, 1'b1};
    tbl[4] = '{2'b10, 2'b10, 1'b0};
    tbl[5] = '{2'b10, 2'b01, 1'b1};
    tbl[6] = '{2'b00, 2'b01, 1'b1};
    tbl[7] = '{2'b10, 2'b10, 1'b0};

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(sched_busy), 0);
    check("rst_starts", 32'({cam1_start, cam0_start}), 0);
    check("rst_resets", 32'({cam1_reset, cam0_reset}), 0);
    check("rst_count", 32'(frame_count), 0);
    check("rst_flags", 32'({next_cam, timeout_err, overrun}), 0);
    @(negedge clk); reset_n = 1'b1;

    // Periodic cam0 only, done after 50 cycles, period 100
    mode = 2'b00; period = 100; timeout = '0; resp_en = 2'b01; dly0 = 50;
    repeat (4) exp_q.push_back(2'b01);
    starts.delete();
    run_periodic(4, 600);
    for (int i = 1; i < starts.size(); i++) check("B_interval", 32'(starts[i] - starts[i-1]), 100);
    fc_exp = fc_exp + CW'(4);
    check("B_count", 32'(frame_count), 32'(fc_exp));

    // Alternating, period 20
    mode = 2'b10; period = 20; resp_en = 2'b11; dly0 = 3; dly1 = 3;
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    starts.delete();
    run_periodic(4, 200);
    fc_exp = fc_exp + CW'(4);
    check("C_count", 32'(frame_count), 32'(fc_exp));
    check("C_next_cam", 32'(next_cam), 0);
    check("C_overrun", 32'(overrun), 0);

    // One-shot trigger table (enable=0); frame_count wraps within it
    for (int i = 0; i < 8; i++) begin
      mode = tbl[i].mode;
      exp_q.push_back(tbl[i].mask);
      trigger_pulse(tc);
      wait_idle(100, f);
      check("T_latency", 32'(last_start - tc), 2);
      fc_exp = fc_exp + CW'(1);
      check("T_count", 32'(frame_count), 32'(fc_exp));
      check("T_next_cam", 32'(next_cam), 32'(tbl[i].nxt_after));
    end

    // Both cameras, cam1 done 10 cycles after cam0
    mode = 2'b11; dly0 = 5; dly1 = 15;
    exp_q.push_back(2'b11);
    trigger_pulse(tc);
    wait_idle(100, f);
    check("D_busy_fall", 32'(f - last_start), 16);
    fc_exp = fc_exp + CW'(1);
    check("D_count", 32'(frame_count), 32'(fc_exp));

    // FIFO almost-full hold-off with overrun
    mode = 2'b00; period = 10; resp_en = 2'b01; dly0 = 3; cam0_fifo_afull = 1'b1;
    @(negedge clk); enable = 1'b1;
    repeat (35) @(negedge clk);
    check("E_held_busy", 32'(sched_busy), 1);
    check("E_overrun_set", 32'(overrun), 1);
    exp_q.push_back(2'b01);
    cam0_fifo_afull = 1'b0; enable = 1'b0; dc = cyc;
    n = 0;
    while (starts.size() == 0 || last_start < dc) begin
      @(negedge clk); n++;
      if (n > 20) break;
    end
    check("E_start_after_drop", 32'((last_start - dc >= 1) && (last_start - dc <= 2)), 1);
    wait_idle(100, f);
    fc_exp = fc_exp + CW'(1);
    check("E_count", 32'(frame_count), 32'(fc_exp));
    check("E_overrun_sticky", 32'(overrun), 1);
    pulse_clear();
    check("E_overrun_clear", 32'(overrun), 0);

    // Watchdog: both targeted, only cam0 answers
    mode = 2'b11; timeout = 200; resp_en = 2'b01; dly0 = 5;
    exp_q.push_back(2'b11);
    trigger_pulse(tc);
    n = 0; r0 = 0; r1 = 0; te = -1;
    while (sched_busy && n < 400) begin
      if (cam0_reset) r0++;
      if (cam1_reset) r1++;
      if (timeout_err && te < 0) te = cyc;
      @(negedge clk); n++;
    end
    check("F_idle", 32'(sched_busy), 0);
    check("F_err_time", 32'(te - last_start), 201);
    check("F_cam1_reset_len", 32'(r1), 4);
    check("F_cam0_reset_len", 32'(r0), 0);
    check("F_count", 32'(frame_count), 32'(fc_exp));
    check("F_next_cam", 32'(next_cam), 0);
    check("F_err_sticky", 32'(timeout_err), 1);
    pulse_clear();
    check("F_err_clear", 32'(timeout_err), 0);

    // Final done on the expiry cycle wins; one cycle later it does not
    mode = 2'b00; timeout = 30; dly0 = 30;
    exp_q.push_back(2'b01);
    trigger_pulse(tc);
    wait_idle(100, f);
    fc_exp = fc_exp + CW'(1);
    check("G_tie_err", 32'(timeout_err), 0);
    check("G_tie_count", 32'(frame_count), 32'(fc_exp));
    dly0 = 31;
    exp_q.push_back(2'b01);
    trigger_pulse(tc);
    wait_idle(100, f);
    check("G_late_err", 32'(timeout_err), 1);
    check("G_late_count", 32'(frame_count), 32'(fc_exp));
    pulse_clear();

    // Asynchronous reset in WAIT
    timeout = '0; resp_en = 2'b00;
    exp_q.push_back(2'b01);
    trigger_pulse(tc);
    repeat (5) @(negedge clk);
    check("H_pre_busy", 32'(sched_busy), 1);
    reset_n = 1'b0;
    #1;
    check("H_busy", 32'(sched_busy), 0);
    check("H_count", 32'(frame_count), 0);
    check("H_outs", 32'({cam1_start, cam0_start, cam1_reset, cam0_reset, next_cam, timeout_err, overrun}), 0);
    @(negedge clk); reset_n = 1'b1;
    fc_exp = '0;

    resp_en = 2'b01; dly0 = 3;
    exp_q.push_back(2'b01);
    trigger_pulse(tc);
    wait_idle(100, f);
    fc_exp = fc_exp + CW'(1);
    check("H_after_count", 32'(frame_count), 32'(fc_exp));
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
